// File: rtl/alu_issue_slice_pkg.sv
// Shared definitions for the ALU issue slice.
// Holds the default operand, tag and buffer sizes and the ALU operation
// encoding, which follows RV32I funct3.
package alu_issue_slice_pkg;

    localparam int XLEN_DEFAULT      = 32;
    localparam int TAG_WIDTH_DEFAULT = 32;
    localparam int BUF_DEPTH_DEFAULT = 4;

    // The sign modifier turns ADD into SUB and SRL into SRA.
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SLL  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SRL  = 3'd5,
        ALU_OR   = 3'd6,
        ALU_AND  = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_issue_slice_alu_functional_unit.sv
// Combinational integer ALU.
// Ports: a_i/b_i operands, op_i operation (RV32I funct3), sign_i selects
// SUB/SRA; result_o is the XLEN-bit result.
module alu_functional_unit
    import alu_issue_slice_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      op_i,
    input  logic            sign_i,
    output logic [XLEN-1:0] result_o
);

    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    // SRA is written as its own statement so the signed shift is not
    // absorbed into an unsigned ternary context.
    always_comb begin
        result_o = '0;
        case (alu_op_e'(op_i))
            ALU_ADD:  result_o = sign_i ? a_i - b_i : a_i + b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL: begin
                if (sign_i) begin
                    result_o = $signed(a_i) >>> shamt;
                end else begin
                    result_o = a_i >> shamt;
                end
            end
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_slice_functional_unit_output_buffer.sv
// FIFO of finished results waiting for a CDB grant.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i with
// push_data_i/push_tag_i enqueues; pop_req_i dequeues when not empty;
// head_data_o/head_tag_o show the oldest entry; not_empty_o, full_o status.
module functional_unit_output_buffer
    import alu_issue_slice_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT,
    parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [XLEN-1:0]      push_data_i,
    input  logic [TAG_WIDTH-1:0] push_tag_i,
    input  logic                 pop_req_i,
    output logic [XLEN-1:0]      head_data_o,
    output logic [TAG_WIDTH-1:0] head_tag_o,
    output logic                 not_empty_o,
    output logic                 full_o
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]      data_mem [BUF_DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem  [BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 do_push, do_pop;

    assign not_empty_o = count_q != '0;
    assign full_o      = count_q == CNT_W'(BUF_DEPTH);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_req_i && not_empty_o;
    assign head_data_o = data_mem[rd_ptr_q];
    assign head_tag_o  = tag_mem[rd_ptr_q];

    // Storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            data_mem[wr_ptr_q] <= push_data_i;
            tag_mem[wr_ptr_q]  <= push_tag_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_slice_reservation_station.sv
// Single-entry reservation station.
// Ports: clk_i/rst_ni clock and async active-low reset; enable_i plus the
// *_i operand fields issue an instruction; cdb_active_i/cdb_tag_i/cdb_data_i
// snoop the common data bus; fu_accept_i marks the entry as dispatched.
// Outputs are the stored fields, busy_o and ready_o.
module reservation_station
    import alu_issue_slice_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [TAG_WIDTH-1:0] q1_i,
    input  logic [TAG_WIDTH-1:0] q2_i,
    input  logic [XLEN-1:0]      v1_i,
    input  logic [XLEN-1:0]      v2_i,
    input  logic [2:0]           op_i,
    input  logic                 sign_i,
    input  logic [TAG_WIDTH-1:0] rob_tag_i,
    input  logic                 cdb_active_i,
    input  logic [TAG_WIDTH-1:0] cdb_tag_i,
    input  logic [XLEN-1:0]      cdb_data_i,
    input  logic                 fu_accept_i,
    output logic [TAG_WIDTH-1:0] q1_o,
    output logic [TAG_WIDTH-1:0] q2_o,
    output logic [XLEN-1:0]      v1_o,
    output logic [XLEN-1:0]      v2_o,
    output logic [2:0]           op_o,
    output logic                 sign_o,
    output logic [TAG_WIDTH-1:0] rob_tag_o,
    output logic                 busy_o,
    output logic                 ready_o
);

    logic [TAG_WIDTH-1:0] q1_q, q2_q, rob_tag_q;
    logic [XLEN-1:0]      v1_q, v2_q;
    logic [2:0]           op_q;
    logic                 sign_q, busy_q, dispatched_q;

    // Completion (our own ROB tag seen on the bus) wins over everything and
    // empties the entry. An idle station only listens to issue, but a
    // broadcast in the issue cycle is still captured so a value is never
    // missed between the rename stage and the station.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q1_q         <= '0;
            q2_q         <= '0;
            v1_q         <= '0;
            v2_q         <= '0;
            op_q         <= '0;
            sign_q       <= 1'b0;
            rob_tag_q    <= '0;
            busy_q       <= 1'b0;
            dispatched_q <= 1'b0;
        end else if (busy_q && cdb_active_i && cdb_tag_i == rob_tag_q) begin
            q1_q         <= '0;
            q2_q         <= '0;
            v1_q         <= '0;
            v2_q         <= '0;
            op_q         <= '0;
            sign_q       <= 1'b0;
            rob_tag_q    <= '0;
            busy_q       <= 1'b0;
            dispatched_q <= 1'b0;
        end else if (!busy_q) begin
            if (enable_i) begin
                busy_q       <= 1'b1;
                dispatched_q <= 1'b0;
                op_q         <= op_i;
                sign_q       <= sign_i;
                rob_tag_q    <= rob_tag_i;
                if (cdb_active_i && q1_i != '0 && q1_i == cdb_tag_i) begin
                    q1_q <= '0;
                    v1_q <= cdb_data_i;
                end else begin
                    q1_q <= q1_i;
                    v1_q <= v1_i;
                end
                if (cdb_active_i && q2_i != '0 && q2_i == cdb_tag_i) begin
                    q2_q <= '0;
                    v2_q <= cdb_data_i;
                end else begin
                    q2_q <= q2_i;
                    v2_q <= v2_i;
                end
            end
        end else begin
            if (cdb_active_i && q1_q != '0 && q1_q == cdb_tag_i) begin
                q1_q <= '0;
                v1_q <= cdb_data_i;
            end
            if (cdb_active_i && q2_q != '0 && q2_q == cdb_tag_i) begin
                q2_q <= '0;
                v2_q <= cdb_data_i;
            end
            if (fu_accept_i) begin
                dispatched_q <= 1'b1;
            end
        end
    end

    assign ready_o   = busy_q && q1_q == '0 && q2_q == '0 && !dispatched_q;
    assign q1_o      = q1_q;
    assign q2_o      = q2_q;
    assign v1_o      = v1_q;
    assign v2_o      = v2_q;
    assign op_o      = op_q;
    assign sign_o    = sign_q;
    assign rob_tag_o = rob_tag_q;
    assign busy_o    = busy_q;

endmodule

// File: rtl/alu_issue_slice.sv
// ALU issue slice: reservation station feeding a combinational ALU whose
// results queue in an output buffer until the CDB arbiter grants the bus.
// Ports: clk/reset (async active-low); enable with q/v/op/sign/ROB-tag
// inputs issue one instruction; cdb_active/cdb_permit plus the shared
// tri-state cdb_tag/cdb_data bus; station contents, status flags and
// fu_result are exposed as outputs.
module alu_issue_slice
    import alu_issue_slice_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT,
    parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [TAG_WIDTH-1:0] q1_in,
    input  logic [TAG_WIDTH-1:0] q2_in,
    input  logic [XLEN-1:0]      v1_in,
    input  logic [XLEN-1:0]      v2_in,
    input  logic [2:0]           alu_op_in,
    input  logic                 alu_sign_in,
    input  logic [TAG_WIDTH-1:0] reorder_buffer_tag_in,
    input  logic                 cdb_active,
    input  logic                 cdb_permit,
    inout  wire  [TAG_WIDTH-1:0] cdb_tag,
    inout  wire  [XLEN-1:0]      cdb_data,
    output logic [TAG_WIDTH-1:0] q1_out,
    output logic [XLEN-1:0]      v1_out,
    output logic [TAG_WIDTH-1:0] q2_out,
    output logic [XLEN-1:0]      v2_out,
    output logic [2:0]           alu_op_out,
    output logic                 alu_sign_out,
    output logic [TAG_WIDTH-1:0] reorder_buffer_tag_out,
    output logic                 busy,
    output logic                 ready_to_execute,
    output logic                 fu_accept,
    output logic                 fu_write_to_buf,
    output logic                 output_buf_not_empty,
    output logic [XLEN-1:0]      fu_result
);

    logic                 buf_full;
    logic                 drive_cdb;
    logic [XLEN-1:0]      head_data;
    logic [TAG_WIDTH-1:0] head_tag;

    // The ALU takes one cycle of station occupancy; a full buffer stalls it
    // so no finished result is ever dropped.
    assign fu_accept       = ready_to_execute && !buf_full;
    assign fu_write_to_buf = fu_accept;
    assign drive_cdb       = cdb_permit && output_buf_not_empty;
    assign cdb_data        = drive_cdb ? head_data : {XLEN{1'bz}};
    assign cdb_tag         = drive_cdb ? head_tag : {TAG_WIDTH{1'bz}};

    reservation_station #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH)) u_station (
        .clk_i        (clk),
        .rst_ni       (reset),
        .enable_i     (enable),
        .q1_i         (q1_in),
        .q2_i         (q2_in),
        .v1_i         (v1_in),
        .v2_i         (v2_in),
        .op_i         (alu_op_in),
        .sign_i       (alu_sign_in),
        .rob_tag_i    (reorder_buffer_tag_in),
        .cdb_active_i (cdb_active),
        .cdb_tag_i    (cdb_tag),
        .cdb_data_i   (cdb_data),
        .fu_accept_i  (fu_accept),
        .q1_o         (q1_out),
        .q2_o         (q2_out),
        .v1_o         (v1_out),
        .v2_o         (v2_out),
        .op_o         (alu_op_out),
        .sign_o       (alu_sign_out),
        .rob_tag_o    (reorder_buffer_tag_out),
        .busy_o       (busy),
        .ready_o      (ready_to_execute)
    );

    alu_functional_unit #(.XLEN(XLEN)) u_alu (
        .a_i      (v1_out),
        .b_i      (v2_out),
        .op_i     (alu_op_out),
        .sign_i   (alu_sign_out),
        .result_o (fu_result)
    );

    functional_unit_output_buffer #(
        .XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .BUF_DEPTH(BUF_DEPTH)
    ) u_outbuf (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (fu_write_to_buf),
        .push_data_i (fu_result),
        .push_tag_i  (reorder_buffer_tag_out),
        .pop_req_i   (cdb_permit),
        .head_data_o (head_data),
        .head_tag_o  (head_tag),
        .not_empty_o (output_buf_not_empty),
        .full_o      (buf_full)
    );

endmodule

// File: tb/tb_alu_issue_slice.sv
// Self-checking bench for alu_issue_slice. The bench also acts as another
// producer on the shared CDB; it drives zeros onto the bus to confirm the
// slice is released (any slice drive would corrupt the observed value).
module tb_alu_issue_slice;
    import alu_issue_slice_pkg::*;

    localparam int XLEN  = 32;
    localparam int TW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, enable, alu_sign_in, cdb_active, cdb_permit;
    logic [TW-1:0]   q1_in, q2_in, reorder_buffer_tag_in;
    logic [XLEN-1:0] v1_in, v2_in;
    logic [2:0]      alu_op_in;
    logic [TW-1:0]   q1_out, q2_out, reorder_buffer_tag_out;
    logic [XLEN-1:0] v1_out, v2_out, fu_result;
    logic [2:0]      alu_op_out;
    logic            alu_sign_out, busy, ready_to_execute, fu_accept;
    logic            fu_write_to_buf, output_buf_not_empty;

    logic            tbCdbDrive;
    logic [TW-1:0]   tbCdbTag;
    logic [XLEN-1:0] tbCdbData;
    wire  [TW-1:0]   cdb_tag;
    wire  [XLEN-1:0] cdb_data;
    assign cdb_tag  = tbCdbDrive ? tbCdbTag  : {TW{1'bz}};
    assign cdb_data = tbCdbDrive ? tbCdbData : {XLEN{1'bz}};

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [TW-1:0]   tag;
    } sbEntry_t;
    sbEntry_t sb[$];

    typedef struct {
        logic [2:0]      op;
        logic            sign;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
    } opRow_t;

    opRow_t opTable[20] = '{
        '{3'd0, 1'b0, 32'hFFFFFFF8, 32'h2, 32'hFFFFFFFA},
        '{3'd0, 1'b1, 32'hFFFFFFF8, 32'h2, 32'hFFFFFFF6},
        '{3'd1, 1'b0, 32'hFFFFFFF8, 32'h2, 32'hFFFFFFE0},
        '{3'd2, 1'b0, 32'hFFFFFFF8, 32'h2, 32'h1},
        '{3'd3, 1'b0, 32'hFFFFFFF8, 32'h2, 32'h0},
        '{3'd4, 1'b0, 32'hFFFFFFF8, 32'h2, 32'hFFFFFFFA},
        '{3'd5, 1'b0, 32'hFFFFFFF8, 32'h2, 32'h3FFFFFFE},
        '{3'd5, 1'b1, 32'hFFFFFFF8, 32'h2, 32'hFFFFFFFE},
        '{3'd7, 1'b0, 32'hFFFFFFF8, 32'h2, 32'h0},
        '{3'd0, 1'b1, 32'h80000000, 32'h21, 32'h7FFFFFDF},
        '{3'd5, 1'b0, 32'h80000000, 32'h21, 32'h40000000},
        '{3'd5, 1'b1, 32'h80000000, 32'h21, 32'hC0000000},
        '{3'd1, 1'b0, 32'h40000001, 32'h21, 32'h80000002},
        '{3'd3, 1'b0, 32'h2, 32'hFFFFFFF8, 32'h1},
        '{3'd2, 1'b0, 32'h2, 32'hFFFFFFF8, 32'h0},
        '{3'd6, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0},
        '{3'd7, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0},
        '{3'd4, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00},
        '{3'd0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0},
        '{3'd6, 1'b1, 32'h12340000, 32'h00005678, 32'h12345678}
    };

    int checkCount = 0;
    int passCount  = 0;

    alu_issue_slice #(.XLEN(XLEN), .TAG_WIDTH(TW), .BUF_DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable                 (enable),
        .q1_in                  (q1_in),
        .q2_in                  (q2_in),
        .v1_in                  (v1_in),
        .v2_in                  (v2_in),
        .alu_op_in              (alu_op_in),
        .alu_sign_in            (alu_sign_in),
        .reorder_buffer_tag_in  (reorder_buffer_tag_in),
        .cdb_active             (cdb_active),
        .cdb_permit             (cdb_permit),
        .cdb_tag                (cdb_tag),
        .cdb_data               (cdb_data),
        .q1_out                 (q1_out),
        .v1_out                 (v1_out),
        .q2_out                 (q2_out),
        .v2_out                 (v2_out),
        .alu_op_out             (alu_op_out),
        .alu_sign_out           (alu_sign_out),
        .reorder_buffer_tag_out (reorder_buffer_tag_out),
        .busy                   (busy),
        .ready_to_execute       (ready_to_execute),
        .fu_accept              (fu_accept),
        .fu_write_to_buf        (fu_write_to_buf),
        .output_buf_not_empty   (output_buf_not_empty),
        .fu_result              (fu_result)
    );

    task automatic checkOutput(input string name, input logic [63:0] obs,
                               input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    endtask

    // Called at a falling edge; issues on the next rising edge and returns
    // at the following falling edge with enable dropped.
    task automatic applyStimulus(input logic [TW-1:0] q1, input logic [TW-1:0] q2,
                                 input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2,
                                 input logic [2:0] op, input logic sign,
                                 input logic [TW-1:0] rob);
        enable = 1'b1;
        q1_in = q1;
        q2_in = q2;
        v1_in = v1;
        v2_in = v2;
        alu_op_in = op;
        alu_sign_in = sign;
        reorder_buffer_tag_in = rob;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic waitNotEmpty(input string name);
        for (int i = 0; i < 8 && !output_buf_not_empty; i++) @(negedge clk);
        checkOutput(name, output_buf_not_empty, 1);
    endtask

    // Grants the bus to the slice, compares the head against the oldest
    // scoreboard entry and lets the pop/completion edge happen.
    task automatic checkBroadcast(input string name);
        sbEntry_t e;
        tbCdbDrive = 1'b0;
        cdb_permit = 1'b1;
        cdb_active = 1'b1;
        #1;
        checkOutput({name, "_sb"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput({name, "_data"}, cdb_data, e.data);
            checkOutput({name, "_tag"}, cdb_tag, e.tag);
        end
        @(posedge clk);
        @(negedge clk);
        cdb_permit = 1'b0;
        cdb_active = 1'b0;
    endtask

    task automatic runOp(input int idx);
        applyStimulus('0, '0, opTable[idx].a, opTable[idx].b,
                      opTable[idx].op, opTable[idx].sign, TW'(20 + idx));
        sb.push_back({opTable[idx].exp, TW'(20 + idx)});
        waitNotEmpty($sformatf("op%0d_wait", idx));
        checkBroadcast($sformatf("op%0d", idx));
        checkOutput($sformatf("op%0d_busy_clear", idx), busy, 0);
    endtask

    task automatic checkBusReleased(input string name);
        tbCdbDrive = 1'b1;
        tbCdbTag = '0;
        tbCdbData = '0;
        #1;
        checkOutput({name, "_cdb_data"}, cdb_data, 0);
        checkOutput({name, "_cdb_tag"}, cdb_tag, 0);
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, "_busy"}, busy, 0);
        checkOutput({name, "_ready"}, ready_to_execute, 0);
        checkOutput({name, "_accept"}, fu_accept, 0);
        checkOutput({name, "_not_empty"}, output_buf_not_empty, 0);
        checkOutput({name, "_q1"}, q1_out, 0);
        checkOutput({name, "_v1"}, v1_out, 0);
        checkOutput({name, "_rob"}, reorder_buffer_tag_out, 0);
        checkBusReleased(name);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        enable = 1'b0;
        q1_in = '0; q2_in = '0; v1_in = '0; v2_in = '0;
        alu_op_in = '0; alu_sign_in = 1'b0; reorder_buffer_tag_in = '0;
        cdb_active = 1'b0;
        cdb_permit = 1'b1;
        tbCdbDrive = 1'b1; tbCdbTag = '0; tbCdbData = '0;
        @(negedge clk);
        checkResetState("reset");
        reset = 1'b1;
        cdb_permit = 1'b0;
        tbCdbDrive = 1'b0;
        @(negedge clk);

        // Instruction waiting on two producers.
        applyStimulus(32'd10, 32'd12, 32'hDEAD, 32'hBEEF, 3'd0, 1'b0, 32'd19);
        sb.push_back({32'd41, 32'd19});
        checkOutput("issue_busy", busy, 1);
        checkOutput("issue_ready", ready_to_execute, 0);
        checkOutput("issue_accept", fu_accept, 0);
        checkOutput("issue_not_empty", output_buf_not_empty, 0);
        checkOutput("issue_q1", q1_out, 10);
        checkOutput("issue_q2", q2_out, 12);
        checkOutput("issue_rob", reorder_buffer_tag_out, 19);

        cdb_active = 1'b1;
        tbCdbDrive = 1'b1; tbCdbTag = 32'd10; tbCdbData = 32'd24;
        @(posedge clk);
        @(negedge clk);
        checkOutput("snoop1_v1", v1_out, 24);
        checkOutput("snoop1_q1", q1_out, 0);
        checkOutput("snoop1_q2", q2_out, 12);
        checkOutput("snoop1_ready", ready_to_execute, 0);
        tbCdbTag = 32'd12; tbCdbData = 32'd17;
        @(posedge clk);
        @(negedge clk);
        cdb_active = 1'b0;
        checkOutput("snoop2_v2", v2_out, 17);
        checkOutput("snoop2_q2", q2_out, 0);
        checkOutput("snoop2_ready", ready_to_execute, 1);
        checkOutput("snoop2_result", fu_result, 41);
        checkOutput("snoop2_write", fu_write_to_buf, 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("dispatch_ready", ready_to_execute, 0);
        checkOutput("dispatch_not_empty", output_buf_not_empty, 1);
        checkBusReleased("dispatch");

        checkBroadcast("complete");
        checkOutput("complete_busy", busy, 0);
        checkOutput("complete_v1", v1_out, 0);
        checkOutput("complete_rob", reorder_buffer_tag_out, 0);
        checkOutput("complete_not_empty", output_buf_not_empty, 0);

        for (int i = 0; i < 20; i++) runOp(i);

        // Fill the buffer with no grant; the bench completes each entry
        // itself so the station can take the next one.
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus('0, '0, XLEN'(k), 32'd100, 3'd0, 1'b0, TW'(40 + k));
            sb.push_back({XLEN'(100 + k), TW'(40 + k)});
            checkOutput($sformatf("fill%0d_accept", k), fu_accept, 1);
            @(posedge clk);
            @(negedge clk);
            cdb_active = 1'b1;
            tbCdbDrive = 1'b1; tbCdbTag = TW'(40 + k); tbCdbData = '0;
            @(posedge clk);
            @(negedge clk);
            cdb_active = 1'b0;
            tbCdbDrive = 1'b0;
            checkOutput($sformatf("fill%0d_busy", k), busy, 0);
        end
        applyStimulus('0, '0, 32'd4, 32'd100, 3'd0, 1'b0, 32'd44);
        sb.push_back({32'd104, 32'd44});
        checkOutput("full_ready", ready_to_execute, 1);
        checkOutput("full_accept", fu_accept, 0);
        checkOutput("full_write", fu_write_to_buf, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("full_hold_accept", fu_accept, 0);
        checkOutput("full_hold_ready", ready_to_execute, 1);
        checkBroadcast("full_pop");
        checkOutput("after_pop_accept", fu_accept, 1);
        checkOutput("after_pop_busy", busy, 1);

        // Asynchronous reset in the middle of a stalled, populated run.
        #2;
        reset = 1'b0;
        #1;
        cdb_permit = 1'b1;
        checkResetState("midreset");
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_hold_not_empty", output_buf_not_empty, 0);
        sb.delete();
        reset = 1'b1;
        cdb_permit = 1'b0;
        tbCdbDrive = 1'b0;
        @(negedge clk);
        runOp(16);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_issue_slice.md
ALU_ISSUE_SLICE -- requirements
Module: alu_issue_slice

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter TAG_WIDTH, default 32, ROB/CDB tag width; tag value 0 means "operand valid, no producer".
REQ-003 Parameter BUF_DEPTH, default 4, output-buffer entries (power of two).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 enable  in  1  issue strobe; loads the station.
REQ-007 q1_in, q2_in  in  TAG_WIDTH  producer tags of operands 1/2.
REQ-008 v1_in, v2_in  in  XLEN  operand values; meaningful when the matching q is 0.
REQ-009 alu_op_in  in  3  operation select; alu_sign_in  in  1  sub/arithmetic-shift modifier.
REQ-010 reorder_buffer_tag_in  in  TAG_WIDTH  destination ROB tag.
REQ-011 cdb_active  in  1  CDB carries a valid broadcast this cycle.
REQ-012 cdb_permit  in  1  arbiter grant for this slice to drive the CDB.
REQ-013 cdb_tag  inout  TAG_WIDTH; cdb_data  inout  XLEN: shared tri-state CDB.
REQ-014 q1_out, v1_out, q2_out, v2_out, alu_op_out, alu_sign_out, reorder_buffer_tag_out  out: station contents.
REQ-015 busy, ready_to_execute, fu_accept, fu_write_to_buf, output_buf_not_empty  out  1; fu_result  out  XLEN.

Function
REQ-016 Issue: enable while !busy latches all *_in fields, sets busy, clears dispatched; enable while busy is ignored.
REQ-017 Snoop: each cycle cdb_active && busy && qN!=0 && qN==cdb_tag loads vN<=cdb_data, qN<=0, per operand independently.
REQ-018 Issue and CDB match in the same cycle: the matching operand is captured from the CDB (q stored as 0).
REQ-019 ready_to_execute = busy && q1==0 && q2==0 && !dispatched, combinational from registers.
REQ-020 FU is combinational: fu_accept = fu_write_to_buf = ready_to_execute && !buffer_full; the station sets dispatched on the edge where fu_accept is high, so ready_to_execute drops the next cycle.
REQ-021 ALU ops (RV32I funct3): 0 add (sign=1: sub), 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl (sign=1: sra), 6 or, 7 and; shifts use b[4:0]; add/sub wrap modulo 2^XLEN.
REQ-022 Completion: cdb_active && busy && cdb_tag==reorder_buffer_tag_out clears busy, dispatched, all q/v/op/tag fields to 0 on that edge.
REQ-023 Output buffer: FIFO; fu_write_to_buf pushes {fu_result, reorder_buffer_tag_out}; output_buf_not_empty = count!=0.
REQ-024 CDB drive: cdb_permit && not_empty drives head entry onto cdb_data/cdb_tag combinationally; otherwise both are high-Z.
REQ-025 Pop on edge when cdb_permit && not_empty; simultaneous push and pop allowed, count unchanged; pointers wrap modulo BUF_DEPTH.
REQ-026 Full buffer: fu_accept held low, no push, station waits; pushes never lost.

Reset
REQ-027 reset low: busy, dispatched, all station fields, FIFO pointers and count 0 asynchronously; CDB outputs high-Z; ready_to_execute, fu_accept, output_buf_not_empty 0.
REQ-028 Reset mid-operation discards station contents and all buffered results.

Structure
REQ-029 Shared package holds XLEN/TAG_WIDTH defaults and the alu_op encoding enum.
REQ-030 Top instantiates sub-modules reservation_station, alu_functional_unit, functional_unit_output_buffer, wired exactly as REQ-016..026.

Verification
REQ-031 Issue q1=10, q2=12, op=0, tag=19 -> busy=1, ready_to_execute=0, fu_accept=0, not_empty=0.
REQ-032 CDB active tag=10 data=24, then tag=12 data=17 -> v1=24,q1=0; next v2=17,q2=0, ready_to_execute=1, fu_result=41, fu_write_to_buf=1.
REQ-033 One edge later, CDB released -> ready_to_execute=0, not_empty=1, cdb high-Z.
REQ-034 cdb_permit=1, cdb_active=1 -> cdb_data=41, cdb_tag=19 before edge; after edge busy=0, fields 0, not_empty=0.
REQ-035 Ops sweep: a=-8, b=2 -> sub -10, sra -2, srl 0x3FFFFFFE, slt 1, sltu 0.
REQ-036 Fill buffer with cdb_permit=0 -> fu_accept held 0 at BUF_DEPTH entries; assert reset mid-run -> all outputs per REQ-027.
